// File: rtl/dl_arb_pkg.sv
// Shared types and helpers for the round-robin write arbiter.
package dl_arb_pkg;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // Index width for n requesters, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dl_rr_pick.sv
// Rotating-priority search: picks the first asserted request at or after ptr,
// wrapping around to index 0.
module dl_rr_pick
    import dl_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int unsigned ptr_u;
    logic        found;

    assign ptr_u = 32'(ptr);

    // First pass covers ptr..NUM_REQ-1; second pass only reaches 0..ptr-1
    // because anything above ptr would already have been taken.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= ptr_u)) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/dl_rr_arb_wr.sv
// Round-robin write arbiter feeding a single registered output word.
// Optional per-requester priority lock enabled by DL_RR_ARB_LOCK_EN.
module dl_rr_arb_wr
    import dl_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_BITS-1:0]  data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         out_valid,
    output logic [NUM_BITS-1:0]          out_data,
    output logic [idx_w(NUM_REQ)-1:0]    out_src,
    input  logic                         out_ready
`ifdef DL_RR_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]           lock
`endif
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_BITS-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_src_q, out_src_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                load;
    logic                xfer;
    logic [NUM_BITS-1:0] win_data;
    logic [IDX_W-1:0]    ptr_adv;

    dl_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign load = (state_q == ARB_EMPTY) || out_ready;
    assign gnt  = (rst_n && load) ? pick_oh : '0;
    assign xfer = rst_n && load && pick_any;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                win_data = data[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: if (xfer) state_d = ARB_FULL;
            ARB_FULL:  if (out_ready && !xfer) state_d = ARB_EMPTY;
            default:   state_d = ARB_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == ARB_FULL);
    end

    assign ptr_adv = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

    always_comb begin
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (xfer) begin
            out_data_d = win_data;
            out_src_d  = pick_idx;
`ifdef DL_RR_ARB_LOCK_EN
            ptr_d      = (|(lock & pick_oh)) ? pick_idx : ptr_adv;
`else
            ptr_d      = ptr_adv;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_dl_rr_arb_wr.sv
// Self-checking bench for dl_rr_arb_wr (4 requesters, 32-bit data) with a
// reference model and a scoreboard of granted words.
module tb_dl_rr_arb_wr;

    localparam int unsigned NR = 4;
    localparam int unsigned NB = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*NB-1:0] data;
    logic [NR-1:0]   gnt;
    logic            out_valid;
    logic [NB-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_ready;
`ifdef DL_RR_ARB_LOCK_EN
    logic [NR-1:0]   lock;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [NB-1:0] d;
        logic [1:0]    s;
    } word_t;

    word_t       sb[$];
    int unsigned m_ptr;
    logic        m_valid;
    logic [NB-1:0] m_last_d;
    logic [1:0]  m_last_s;
    logic [NR-1:0] obs_gnt;

    logic [NR-1:0] rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};

    dl_rr_arb_wr #(
        .NUM_REQ  (NR),
        .NUM_BITS (NB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef DL_RR_ARB_LOCK_EN
        ,
        .lock      (lock)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [NB-1:0] v);
        data[i*NB +: NB] = v;
    endtask

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [NR-1:0] model_gnt();
        logic [2*NR-1:0] dbl;
        logic [NR-1:0]   rot;
        if (!rst_n || !(!m_valid || out_ready)) return '0;
        dbl = {req, req} >> m_ptr;
        rot = dbl[NR-1:0];
        for (int k = 0; k < NR; k++) begin
            if (rot[k]) return NR'(1 << ((k + m_ptr) % NR));
        end
        return '0;
    endfunction

    task automatic step();
        logic [NR-1:0] eg;
        int            w;
        word_t         e;
        @(negedge clk);
        eg      = model_gnt();
        obs_gnt = gnt;
        check_eq("gnt", gnt, eg);
        check_eq("out_valid", out_valid, m_valid);
        check_eq("out_data", out_data, m_last_d);
        check_eq("out_src", out_src, m_last_s);
        if (m_valid && out_ready && rst_n) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("sb_data", out_data, e.d);
                check_eq("sb_src", out_src, e.s);
            end else begin
                check_eq("sb_empty_valid", out_valid, 0);
            end
        end
        if (!rst_n) begin
            m_ptr = 0; m_valid = 1'b0; m_last_d = '0; m_last_s = '0;
            sb.delete();
        end else if (eg != '0) begin
            w = 0;
            for (int k = 0; k < NR; k++) if (eg[k]) w = k;
            e.d = data[w*NB +: NB];
            e.s = 2'(w);
            sb.push_back(e);
            m_valid  = 1'b1;
            m_last_d = e.d;
            m_last_s = e.s;
`ifdef DL_RR_ARB_LOCK_EN
            m_ptr = lock[w] ? w : (w + 1) % NR;
`else
            m_ptr = (w + 1) % NR;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1; data = '0;
`ifdef DL_RR_ARB_LOCK_EN
        lock = '0;
`endif
        m_ptr = 0; m_valid = 1'b0; m_last_d = '0; m_last_s = '0;
        @(posedge clk);
        #1;

        // Reset: grants held off even with all requests up
        repeat (2) step();
        check_eq("rst_gnt", obs_gnt, 4'b0000);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_valid", out_valid, 0);

        // Full request set rotates through every index
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_word(i, 32'h100 + i);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("rr_seq", obs_gnt, rr_seq[i]);
        end

        // Sparse requests skip idle indices
        req = 4'b1010; set_word(1, 32'hA5); set_word(3, 32'h3C);
        step();
        check_eq("sparse_g1", obs_gnt, 4'b0010);
        check_eq("sparse_d1", out_data, 32'hA5);
        step();
        check_eq("sparse_g3", obs_gnt, 4'b1000);
        check_eq("sparse_d3", out_data, 32'h3C);

        // Backpressure: no grant while the full word is stalled
        req = 4'b0100; out_ready = 1'b0; set_word(2, 32'h77);
        repeat (5) begin
            step();
            check_eq("bp_gnt", obs_gnt, 4'b0000);
            check_eq("bp_hold", out_data, 32'h3C);
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_release", obs_gnt, 4'b0100);

        // Wrap from index 3 back to 0
        req = 4'b1000;
        step();
        check_eq("wrap_g3", obs_gnt, 4'b1000);
        req = 4'b1001;
        step();
        check_eq("wrap_g0", obs_gnt, 4'b0001);

        // Reset while a word is pending
        req = 4'b0001; set_word(0, 32'hDEAD);
        step();
        check_eq("mid_valid", out_valid, 1);
        check_eq("mid_data", out_data, 32'hDEAD);
        req = 4'b0000; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, 0);
        req = 4'b1111;
        step();
        check_eq("mid_rst_gnt", obs_gnt, 4'b0001);

`ifdef DL_RR_ARB_LOCK_EN
        rst_n = 1'b0; req = '0;
        step();
        rst_n = 1'b1;
        req = 4'b0110; lock = 4'b0010;
        repeat (3) begin
            step();
            check_eq("lock_g1", obs_gnt, 4'b0010);
        end
        lock = '0;
        step();
        check_eq("unlock_g1", obs_gnt, 4'b0010);
        step();
        check_eq("unlock_g2", obs_gnt, 4'b0100);
`endif

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < NR; i++) set_word(i, $urandom);
`ifdef DL_RR_ARB_LOCK_EN
            lock = 4'($urandom) & 4'($urandom);
`endif
            step();
        end

        rst_n = 1'b1; req = '0; out_ready = 1'b1;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dl_rr_arb_wr.md
DL_RR_ARB_WR -- requirements
Module: dl_rr_arb_wr

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (1..16).
REQ-002 The block SHALL have parameter NUM_BITS, default 32, giving the data width per requester.
REQ-003 The block SHALL have input clk, 1 bit: the clock, all state updates on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: the reset, synchronous, active-low.
REQ-005 The block SHALL have input req, NUM_REQ bits: per-requester write request.
REQ-006 The block SHALL have input data, NUM_REQ*NUM_BITS bits: requester i's data in bits [i*NUM_BITS +: NUM_BITS].
REQ-007 The block SHALL have output gnt, NUM_REQ bits: one-hot or zero; a transfer from requester i occurs when req[i] and gnt[i] are both high.
REQ-008 The block SHALL have output out_valid, 1 bit: the output register holds a pending word.
REQ-009 The block SHALL have output out_data, NUM_BITS bits: the pending word.
REQ-010 The block SHALL have output out_src, $clog2(NUM_REQ) bits (min 1): the index of the pending word's source.
REQ-011 The block SHALL have input out_ready, 1 bit: the downstream accepts the pending word this cycle.

Function
REQ-012 gnt SHALL be combinational from req, the priority pointer, the output state and out_ready, with no combinational path from data.
REQ-013 A grant SHALL be issued only when load = (!out_valid || out_ready) is high.
REQ-014 Among the asserted requests, the winner SHALL be the first index found scanning ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
REQ-015 The output stage SHALL be a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 On a transfer, out_data, out_src and out_valid=1 SHALL be registered on the next edge, giving 1-cycle latency from grant to out_valid.
REQ-017 In FULL with out_ready=1 and no transfer, the FSM SHALL go to EMPTY; out_data and out_src SHALL hold their values.
REQ-018 In FULL with out_ready=1 and a transfer, the FSM SHALL stay FULL with the new word, giving a throughput of 1 word/cycle.
REQ-019 In FULL with out_ready=0, gnt SHALL be 0 and out_data and out_src SHALL be stable.
REQ-020 After a transfer from index w, ptr SHALL become w+1, wrapping from NUM_REQ-1 to 0; with no transfer, ptr SHALL be unchanged.
REQ-021 With NUM_REQ=1, gnt SHALL equal req&load, and out_src SHALL be constant 0.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL set ptr=0, out_valid=0, out_data=0, out_src=0 and FSM=EMPTY.
REQ-023 A reset arriving mid-operation SHALL discard any pending word without handshake.
REQ-024 gnt SHALL be 0 during any cycle in which rst_n=0.

Configuration
REQ-025 When DL_RR_ARB_LOCK_EN is defined, the block SHALL add input lock, NUM_REQ bits.
REQ-026 With DL_RR_ARB_LOCK_EN defined, a transfer from w with lock[w]=1 SHALL set ptr=w (w keeps top priority); a transfer with lock[w]=0 SHALL advance ptr per REQ-020.
REQ-027 When DL_RR_ARB_LOCK_EN is undefined, the block SHALL have no lock port, and ptr SHALL always follow REQ-020.

Structure
REQ-028 Package dl_arb_pkg SHALL hold the FSM state enum (ARB_EMPTY, ARB_FULL) and the index-width helper function.
REQ-029 The rotating-priority search SHALL be a combinational sub-module dl_rr_pick (inputs req and ptr; outputs one-hot and index).
REQ-030 Registers SHALL use synchronous active-low reset only; latches SHALL NOT be used.

Verification
REQ-031 Reset test: after reset, req=4'b1111 and out_ready=1 for 8 cycles SHALL give gnt sequence 0001,0010,0100,1000,0001,... and out_src 0,1,2,3,0,... one cycle later.
REQ-032 Sparse test: from ptr=0, req=4'b1010 with data1=0xA5, data3=0x3C and out_ready=1 SHALL grant 1 then 3, with out_data 0xA5 then 0x3C.
REQ-033 Backpressure test: in FULL with out_ready=0 for 5 cycles and req=4'b0100, gnt SHALL be 0 and out_data stable; when out_ready rises, gnt SHALL be 0100 in that same cycle.
REQ-034 Wrap test: after a grant to 3, with req=4'b1001, the next grant SHALL be 0.
REQ-035 Mid-operation reset test: with out_valid=1 and data 0xDEAD, asserting rst_n=0 for 1 cycle SHALL give out_valid=0, out_data=0 and the next grant to index 0.
REQ-036 Lock test (DL_RR_ARB_LOCK_EN defined): with req=4'b0110 and lock[1]=1 for 3 cycles, the block SHALL grant 1 three times, then grant 2 after lock[1] drops.
